mem_access_stage: RTL
=====================

Name: mem_access_stage

Overview:
- Pipeline stage directly downstream of the execute datapath.
- Consumes the effective address (datapath_out), store data (str_data) and destination register of an LDR/STR.
- Runs a req/gnt/rvalid handshake with the word-addressed data RAM.
- Produces the load write-back triple (w_data_ldr, w_addr_ldr, w_en_ldr) that the regfile and the forwarding muxes consume, and back-pressures execute via ex_ready.

Parameters:
ADDR_W, 11, word-address width to data RAM (2048 words)
TIMEOUT, 64, max cycles in REQ+RESP before bus error (>=2)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
ex_valid  in  1  execute presents an operation this cycle
ex_ready  out  1  stage can accept (high only in IDLE)
ex_is_ldr  in  1  operation is a load
ex_is_str  in  1  operation is a store
ex_addr  in  32  byte effective address (datapath_out)
ex_str_data  in  32  store data (str_data)
ex_rd  in  4  load destination register
mem_req  out  1  RAM request, held until mem_gnt
mem_we  out  1  1=write, 0=read; valid with mem_req
mem_addr  out  ADDR_W  word address = ex_addr[ADDR_W+1:2]
mem_wdata  out  32  write data
mem_gnt  in  1  RAM accepted request
mem_rvalid  in  1  read data valid
mem_rdata  in  32  read data
w_en_ldr  out  1  one-cycle load write-back strobe
w_addr_ldr  out  4  write-back register
w_data_ldr  out  32  write-back data
ldr_to_pc  out  1  pulses with w_en_ldr when w_addr_ldr==15
err  out  1  one-cycle pulse: misaligned, out-of-range, ldr&str both set, or timeout
busy  out  1  state != IDLE

Behaviour:
- Reset (async, rst_n=0):
  - State=IDLE.
  - All outputs 0 except ex_ready=1.
  - Timeout counter cleared.
  - Reset mid-transaction abandons it silently; no write-back.
- States: IDLE, REQ, RESP, WB.
- Accept: ex_valid && ex_ready at edge T. Latch op, word address, store data, rd.
  - Neither ldr nor str: no-op, stay IDLE.
  - ldr&&str both set: err pulse at T+1, stay IDLE, no access.
  - ex_addr[1:0]!=0, or ex_addr[31:ADDR_W+2]!=0: err pulse at T+1, stay IDLE, no access, no write-back.
  - Otherwise go to REQ.
- REQ:
  - mem_req=1; mem_we/mem_addr/mem_wdata come from latches and stay stable until gnt.
  - Store + gnt: go to IDLE (store latency min 1 cycle after accept).
  - Load + gnt without rvalid: go to RESP.
  - Load + gnt + rvalid in the same cycle: capture mem_rdata, go to WB.
- RESP: mem_req=0. On mem_rvalid, capture mem_rdata and go to WB. mem_rvalid outside RESP (and outside the REQ+gnt case) is ignored.
- WB:
  - w_en_ldr=1 for exactly one cycle, with w_addr_ldr=latched rd and w_data_ldr=captured data.
  - ldr_to_pc=1 if rd==15.
  - Go to IDLE.
  - Min load latency: accept T -> w_en_ldr at T+3.
- Outside WB: w_en_ldr=0, ldr_to_pc=0; w_addr_ldr/w_data_ldr hold last value (forwarding muxes sample them only with w_en_ldr).
- Timeout:
  - Counter increments each cycle in REQ or RESP and clears on entry to REQ.
  - Reaching TIMEOUT-1 without completion: err pulse, go to IDLE, mem_req drops, no write-back.
  - A late rvalid is ignored.
- ex_ready=1 only in IDLE, so there is never more than one outstanding transaction.
- err is registered: exactly one cycle per event, never concurrent with w_en_ldr.

Decomposition:
- Package mem_stage_pkg: state enum (IDLE, REQ, RESP, WB), PC_REG=4'd15, default TIMEOUT constant.
- One sub-module, mem_timeout_ctr: clear/enable/expired, width $clog2(TIMEOUT).
- FSM, latches and write-back regs live in the top module.

Test Plan:
1. Load, zero-wait RAM (gnt in REQ, rvalid next cycle): ex_addr=0x0000_0010, rd=3, rdata=0xDEADBEEF -> mem_addr=4, mem_we=0; w_en_ldr=1 at T+3 with w_addr_ldr=3, w_data_ldr=0xDEADBEEF; ex_ready low T+1..T+3.
2. Store with gnt delayed 3 cycles: ex_addr=0x20, data=0x1234_5678 -> mem_req/mem_we=1, mem_addr=8, mem_wdata stable for 4 cycles; no w_en_ldr; ex_ready=1 the cycle after gnt.
3. Misaligned load ex_addr=0x22, and out-of-range ex_addr=0x0000_2000 -> err pulse 1 cycle each; mem_req never asserted; no w_en_ldr.
4. Load rd=15, gnt and rvalid in the same cycle, rdata=0x0000_0100 -> w_en_ldr and ldr_to_pc high together at T+2, w_data_ldr=0x100.
5. Load with RAM never granting, TIMEOUT=8 -> mem_req high 8 cycles, then err pulse, IDLE, ex_ready=1; a later rvalid produces no write-back.
6. rst_n low while in RESP -> outputs 0 immediately, ex_ready=1; rvalid after release is ignored.

Source files
------------

// File: rtl/mem_stage_pkg.sv
// rtl/mem_stage_pkg.sv - shared types and constants for the memory access stage
package mem_stage_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2,
    WB   = 2'd3
  } state_t;

  localparam logic [3:0] PC_REG          = 4'd15;
  localparam int         DEFAULT_TIMEOUT = 64;
  localparam int         DEFAULT_ADDR_W  = 11;

endpackage

// File: rtl/mem_access_stage_if.sv
// rtl/mem_access_stage_if.sv - req/gnt/rvalid bus between the stage and the data RAM
interface mem_access_stage_if #(
  parameter int ADDR_W = 11
);

  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              mem_gnt;
  logic              mem_rvalid;
  logic [31:0]       mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_gnt, mem_rvalid, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_gnt, mem_rvalid, mem_rdata
  );

endinterface

// File: rtl/mem_timeout_ctr.sv
// rtl/mem_timeout_ctr.sv - cycle counter that flags an outstanding access as expired
module mem_timeout_ctr #(
  parameter int TIMEOUT = 64
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int            CW   = $clog2(TIMEOUT);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clear) begin
      cnt_q <= '0;
    end else if (enable) begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

  // The owner leaves REQ/RESP on expiry, so the counter never wraps past LAST.
  assign expired = enable && (cnt_q == LAST);

endmodule

// File: rtl/mem_access_stage.sv
// rtl/mem_access_stage.sv - LDR/STR memory stage between execute and the regfile write-back
module mem_access_stage
  import mem_stage_pkg::*;
#(
  parameter int ADDR_W  = DEFAULT_ADDR_W,
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic                 clk,
  input  logic                 rst_n,

  input  logic                 ex_valid,
  output logic                 ex_ready,
  input  logic                 ex_is_ldr,
  input  logic                 ex_is_str,
  input  logic [31:0]          ex_addr,
  input  logic [31:0]          ex_str_data,
  input  logic [3:0]           ex_rd,

  mem_access_stage_if.master   mem,

  output logic                 w_en_ldr,
  output logic [3:0]           w_addr_ldr,
  output logic [31:0]          w_data_ldr,
  output logic                 ldr_to_pc,
  output logic                 err,
  output logic                 busy
);

  state_t            state_q, state_d;
  logic              is_ldr_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [3:0]        rd_q;
  logic              err_q, err_d;
  logic [3:0]        w_addr_q;
  logic [31:0]       w_data_q;

  logic accept;
  logic start;
  logic capture;
  logic misaligned;
  logic out_of_range;
  logic expired;

  assign accept       = ex_valid && (state_q == IDLE);
  assign misaligned   = (ex_addr[1:0] != 2'b00);
  assign out_of_range = |ex_addr[31:ADDR_W+2];

  mem_timeout_ctr #(
    .TIMEOUT (TIMEOUT)
  ) u_timeout (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (start),
    .enable  ((state_q == REQ) || (state_q == RESP)),
    .expired (expired)
  );

  always_comb begin
    state_d = state_q;
    err_d   = 1'b0;
    start   = 1'b0;
    capture = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (ex_is_ldr && ex_is_str) begin
            err_d = 1'b1;
          end else if (ex_is_ldr || ex_is_str) begin
            if (misaligned || out_of_range) begin
              err_d = 1'b1;
            end else begin
              start   = 1'b1;
              state_d = REQ;
            end
          end
        end
      end
      REQ: begin
        // Completion outranks expiry when both land in the same cycle.
        if (mem.mem_gnt) begin
          if (!is_ldr_q) begin
            state_d = IDLE;
          end else if (mem.mem_rvalid) begin
            capture = 1'b1;
            state_d = WB;
          end else begin
            state_d = RESP;
          end
        end else if (expired) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end
      end
      RESP: begin
        if (mem.mem_rvalid) begin
          capture = 1'b1;
          state_d = WB;
        end else if (expired) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end
      end
      WB: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      err_q    <= 1'b0;
      is_ldr_q <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rd_q     <= '0;
      w_addr_q <= '0;
      w_data_q <= '0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
      if (start) begin
        is_ldr_q <= ex_is_ldr;
        addr_q   <= ex_addr[ADDR_W+1:2];
        wdata_q  <= ex_str_data;
        rd_q     <= ex_rd;
      end
      // Write-back regs only move on capture so forwarding sees stable values.
      if (capture) begin
        w_addr_q <= rd_q;
        w_data_q <= mem.mem_rdata;
      end
    end
  end

  assign ex_ready      = (state_q == IDLE);
  assign busy          = (state_q != IDLE);
  assign mem.mem_req   = (state_q == REQ);
  assign mem.mem_we    = (state_q == REQ) && !is_ldr_q;
  assign mem.mem_addr  = addr_q;
  assign mem.mem_wdata = wdata_q;

  assign w_en_ldr   = (state_q == WB);
  assign ldr_to_pc  = (state_q == WB) && (w_addr_q == PC_REG);
  assign w_addr_ldr = w_addr_q;
  assign w_data_ldr = w_data_q;
  assign err        = err_q;

endmodule
